uart_tx_port: RTL

Memory-mapped UART transmitter peripheral on the MIPS data bus, alongside the bidirectional I/O port.
- Processor stores bytes into a small TX FIFO; a serialiser shifts them out as 8N1 frames on `tx`.
- Status and baud-divisor registers are readable/writable through the same bus.
- Selected by top-level address decode (`ce`); sub-register chosen by `address`.

---
 rtl/uart_tx_port.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Registers: DATA (push byte), STATUS (flags/count, overflow clear), DIV (baud divisor).
// Optional build macro UART_TX_IRQ_EN adds an irq output and an irq-enable bit in STATUS.
//
//   state | meaning
//   IDLE  | line high, waiting for a byte in the FIFO
//   START | start bit (tx low) for one bit period
//   DATA  | eight data bits, LSB first
//   STOP  | stop bit (tx high) for one bit period
module uart_tx_port #(
    parameter int          CLK_FREQ        = 25000000,
    parameter int          BAUD_RATE       = 115200,
    parameter int          FIFO_DEPTH      = 8,
    parameter logic [3:0]  DATA_REG_ADDR   = 4'b0000,
    parameter logic [3:0]  STATUS_REG_ADDR = 4'b0001,
    parameter logic [3:0]  DIV_REG_ADDR    = 4'b0010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    input  logic [3:0]  address,
    input  logic        rw,
    input  logic        ce,
    output logic        tx
`ifdef UART_TX_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam int              CW        = AW + 1;
    localparam logic [15:0]     DIV_RESET = 16'(CLK_FREQ / BAUD_RATE - 1);
    localparam logic [CW-1:0]   DEPTH_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]   CNT_ONE   = 1;
    localparam logic [AW-1:0]   PTR_ONE   = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t          state, state_next;
    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   fifo_cnt;
    logic            fifo_full, fifo_empty;
    logic            wr_data, wr_status, wr_div;
    logic            push, pop;
    logic            overflow;
    logic [15:0]     div_reg, div_latched, baud_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_reg;
    logic            tick, busy;
    logic            irq_en_bit;
    logic            unused_data_hi;

    assign unused_data_hi = ^data_in[31:16];

    assign wr_data    = ce && rw && (address == DATA_REG_ADDR);
    assign wr_status  = ce && rw && (address == STATUS_REG_ADDR);
    assign wr_div     = ce && rw && (address == DIV_REG_ADDR);
    assign fifo_full  = (fifo_cnt == DEPTH_CNT);
    assign fifo_empty = (fifo_cnt == '0);
    // A full FIFO still accepts a byte when the serialiser pops in the same cycle.
    assign push       = wr_data && (!fifo_full || pop);
    assign tick       = (baud_cnt == 16'd0);
    assign busy       = (state != ST_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state logic and FIFO pop request.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            ST_IDLE:  if (!fifo_empty) begin
                          pop        = 1'b1;
                          state_next = ST_START;
                      end
            ST_START: if (tick) state_next = ST_DATA;
            ST_DATA:  if (tick && (bit_cnt == 3'd7)) state_next = ST_STOP;
            ST_STOP:  if (tick) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // FIFO storage; contents are don't-care after reset since the pointers are cleared.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= data_in[7:0];
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
                2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Divisor register and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg  <= DIV_RESET;
            overflow <= 1'b0;
        end else begin
            if (wr_div) div_reg <= data_in[15:0];
            if (wr_data && fifo_full && !pop) overflow <= 1'b1;
            else if (wr_status && data_in[3])  overflow <= 1'b0;
        end
    end

    // Serialiser: down-counting baud timer, shift register and registered tx.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx          <= 1'b1;
            shift_reg   <= '0;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            div_latched <= DIV_RESET;
        end else begin
            case (state)
                ST_IDLE: if (pop) begin
                    shift_reg   <= fifo_mem[rd_ptr];
                    div_latched <= div_reg;
                    baud_cnt    <= div_reg;
                    bit_cnt     <= '0;
                    tx          <= 1'b0;
                end
                ST_START: if (tick) begin
                    baud_cnt <= div_latched;
                    tx       <= shift_reg[0];
                end else begin
                    baud_cnt <= baud_cnt - 16'd1;
                end
                ST_DATA: if (tick) begin
                    baud_cnt  <= div_latched;
                    bit_cnt   <= bit_cnt + 3'd1;
                    shift_reg <= {1'b0, shift_reg[7:1]};
                    tx        <= (bit_cnt == 3'd7) ? 1'b1 : shift_reg[1];
                end else begin
                    baud_cnt <= baud_cnt - 16'd1;
                end
                ST_STOP: if (!tick) baud_cnt <= baud_cnt - 16'd1;
                default: tx <= 1'b1;
            endcase
        end
    end

`ifdef UART_TX_IRQ_EN
    logic irq_en;

    // Interrupt enable and registered "transmitter drained" interrupt.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (wr_status) irq_en <= data_in[4];
            irq <= irq_en && fifo_empty && (state == ST_IDLE);
        end
    end

    assign irq_en_bit = irq_en;
`else
    assign irq_en_bit = 1'b0;
`endif

    // Combinational register read mux.
    always_comb begin
        data_out = 32'h0;
        if (ce && !rw) begin
            case (address)
                STATUS_REG_ADDR: data_out = {16'h0, 8'(fifo_cnt), 3'b000, irq_en_bit,
                                             overflow, busy, fifo_empty, fifo_full};
                DIV_REG_ADDR:    data_out = {16'h0, div_reg};
                default:         data_out = 32'h0;
            endcase
        end
    end

endmodule
